// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface param_sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 3
) ();
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, data_in, err_clr,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, pop, data_in, err_clr,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with registered read data, occupancy flags
// and sticky overflow/underflow error flags. Usable capacity is 2**ADDR_WIDTH.
module param_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                clk,
    input  logic                reset,
    param_sync_fifo_if.slave    bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q,     wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]      count_q,      count_d;
    logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  overflow_q,   overflow_d;
    logic                  underflow_q,  underflow_d;

    logic full_c;
    logic empty_c;
    logic pop_ok_c;
    logic push_ok_c;
    logic wr_en_c;

    // Occupancy flags decode straight from the registered count.
    assign full_c  = (count_q == CNT_FULL);
    assign empty_c = (count_q == '0);

    // Acceptance on pre-edge state; a full FIFO takes a push only alongside a pop.
    always_comb begin
        pop_ok_c  = 1'b0;
        push_ok_c = 1'b0;
        wr_en_c   = 1'b0;
        pop_ok_c  = bus.pop & ~empty_c;
        push_ok_c = bus.push & (~full_c | pop_ok_c);
        wr_en_c   = push_ok_c & ~reset;
    end

    // Next-state for pointers, occupancy, read data and error flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        overflow_d   = overflow_q & ~bus.err_clr;
        underflow_d  = underflow_q & ~bus.err_clr;

        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end

        if (pop_ok_c) begin
            rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d   = mem_q[rd_ptr_q];
            data_valid_d = 1'b1;
        end

        unique case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A fresh error outranks a simultaneous clear.
        if (bus.push & ~push_ok_c) begin
            overflow_d = 1'b1;
        end
        if (bus.pop & ~pop_ok_c) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is not reset; the read above sees the pre-write word on a same-slot hit.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.almost_empty = (count_q <= CNT_AE);

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised scoreboard bench for param_sync_fifo: a default 8x10 instance and a 16x32 instance,
// each checked against a queue-based model of the FIFO.
module tb_param_sync_fifo;
    localparam int unsigned DW_A = 10;
    localparam int unsigned AW_A = 3;
    localparam int unsigned DW_B = 32;
    localparam int unsigned AW_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    param_sync_fifo_if #(.DATA_WIDTH(DW_A), .ADDR_WIDTH(AW_A)) bus_a ();
    param_sync_fifo_if #(.DATA_WIDTH(DW_B), .ADDR_WIDTH(AW_B)) bus_b ();

    param_sync_fifo #(.DATA_WIDTH(DW_A), .ADDR_WIDTH(AW_A)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    param_sync_fifo #(.DATA_WIDTH(DW_B), .ADDR_WIDTH(AW_B), .AF_THRESH(14), .AE_THRESH(2)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stored words, expected read-out order, and the visible side state.
    logic [31:0] mq0 [$];
    logic [31:0] mq1 [$];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    bit          ovf_m  [2];
    bit          udf_m  [2];
    bit          vld_m  [2];
    logic [31:0] last_m [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus on one instance, model update, then full state check.
    task automatic step(input int inst, input bit rst, input bit push, input bit pop,
                        input logic [31:0] din, input bit clr);
        int          d;
        int          sz;
        bit          pop_ok;
        bit          push_ok;
        logic [31:0] dw;
        logic [31:0] v;
        int          cnt;
        bit          f_full, f_empty, f_af, f_ae, f_dv, f_ovf, f_udf;
        logic [31:0] dout;
        string       p;

        d  = (inst != 0) ? 16 : 8;
        dw = (inst != 0) ? din : (din & 32'h3FF);
        p  = (inst != 0) ? "b." : "a.";
        if (inst == 0) begin
            rst_a = rst; bus_a.push = push; bus_a.pop = pop; bus_a.err_clr = clr;
            bus_a.data_in = dw[DW_A-1:0];
            sz = mq0.size();
        end else begin
            rst_b = rst; bus_b.push = push; bus_b.pop = pop; bus_b.err_clr = clr;
            bus_b.data_in = dw;
            sz = mq1.size();
        end
        pop_ok  = pop && (sz > 0);
        push_ok = push && ((sz < d) || pop_ok);

        @(posedge clk);
        if (rst) begin
            if (inst == 0) mq0.delete(); else mq1.delete();
            ovf_m[inst] = 1'b0; udf_m[inst] = 1'b0; vld_m[inst] = 1'b0; last_m[inst] = '0;
        end else begin
            vld_m[inst] = pop_ok;
            if (pop_ok) begin
                if (inst == 0) begin v = mq0.pop_front(); exp0.push_back(v); end
                else           begin v = mq1.pop_front(); exp1.push_back(v); end
                last_m[inst] = v;
            end
            if (push_ok) begin
                if (inst == 0) mq0.push_back(dw); else mq1.push_back(dw);
            end
            ovf_m[inst] = (push && !push_ok) || (ovf_m[inst] && !clr);
            udf_m[inst] = (pop && !pop_ok) || (udf_m[inst] && !clr);
        end
        #1;

        if (inst == 0) begin
            rst_a = 1'b0; bus_a.push = 1'b0; bus_a.pop = 1'b0; bus_a.err_clr = 1'b0;
            cnt = int'(bus_a.count); f_full = bus_a.full; f_empty = bus_a.empty;
            f_af = bus_a.almost_full; f_ae = bus_a.almost_empty; f_dv = bus_a.data_valid;
            f_ovf = bus_a.overflow; f_udf = bus_a.underflow; dout = 32'(bus_a.data_out);
            sz = mq0.size();
        end else begin
            rst_b = 1'b0; bus_b.push = 1'b0; bus_b.pop = 1'b0; bus_b.err_clr = 1'b0;
            cnt = int'(bus_b.count); f_full = bus_b.full; f_empty = bus_b.empty;
            f_af = bus_b.almost_full; f_ae = bus_b.almost_empty; f_dv = bus_b.data_valid;
            f_ovf = bus_b.overflow; f_udf = bus_b.underflow; dout = bus_b.data_out;
            sz = mq1.size();
        end
        check({p, "count"},        64'(cnt),     64'(sz));
        check({p, "empty"},        64'(f_empty), 64'(sz == 0));
        check({p, "full"},         64'(f_full),  64'(sz == d));
        check({p, "almost_full"},  64'(f_af),    64'(sz >= d - 2));
        check({p, "almost_empty"}, 64'(f_ae),    64'(sz <= 2));
        check({p, "data_valid"},   64'(f_dv),    64'(vld_m[inst]));
        check({p, "data_out"},     64'(dout),    64'(last_m[inst]));
        check({p, "overflow"},     64'(f_ovf),   64'(ovf_m[inst]));
        check({p, "underflow"},    64'(f_udf),   64'(udf_m[inst]));
    endtask

    // Monitors: every valid strobe must match the next word the model popped.
    always @(negedge clk) begin
        logic [31:0] v;
        if (bus_a.data_valid === 1'b1) begin
            if (exp0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a.unexpected_valid: got %0h, required no valid", bus_a.data_out);
            end else begin
                v = exp0.pop_front();
                check("a.rdata", 64'(bus_a.data_out), 64'(v));
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] v;
        if (bus_b.data_valid === 1'b1) begin
            if (exp1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b.unexpected_valid: got %0h, required no valid", bus_b.data_out);
            end else begin
                v = exp1.pop_front();
                check("b.rdata", 64'(bus_b.data_out), 64'(v));
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.push = 1'b0; bus_a.pop = 1'b0; bus_a.err_clr = 1'b0; bus_a.data_in = '0;
        bus_b.push = 1'b0; bus_b.pop = 1'b0; bus_b.err_clr = 1'b0; bus_b.data_in = '0;

        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);

        // Fill to full, drop a ninth push, drain in order.
        for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, 32'(i), 0);
        step(0, 0, 1, 0, 32'h1FF, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);

        // Pop on empty with a simultaneous push: pop rejected, push kept.
        step(0, 0, 1, 1, 32'h155, 0);
        step(0, 0, 0, 1, 0, 0);

        // Simultaneous push/pop at full: read-before-write on the shared slot.
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 32'h0A1, 0);
        for (int i = 2; i <= 8; i++) step(0, 0, 1, 0, 32'h0A0 + 32'(i), 0);
        step(0, 0, 1, 1, 32'h3FF, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);

        // Wrap-around with occupancy cycling 1..3.
        step(0, 0, 1, 0, 32'h200, 0);
        for (int i = 0; i < 20; i++) begin
            if ((i % 4) < 2) step(0, 0, 1, 0, 32'h210 + 32'(i), 0);
            else             step(0, 0, 0, 1, 0, 0);
        end
        while (mq0.size() > 0) step(0, 0, 0, 1, 0, 0);

        // Reset mid-operation with a push pending, then a pop on the emptied FIFO.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 32'h0C0 + 32'(i), 0);
        step(0, 1, 1, 0, 32'h0EE, 0);
        step(0, 0, 0, 1, 0, 0);

        // Error clearing, and set-wins when a clear meets a new overflow.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 32'h300 + 32'(i), 0);
        step(0, 0, 1, 0, 32'h3AA, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 32'h3AB, 1);
        step(0, 1, 0, 0, 0, 0);

        // Randomised traffic on the default instance.
        for (int i = 0; i < 300; i++) begin
            step(0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 50), $urandom, ($urandom_range(0, 99) < 6));
        end

        // Wide/deep instance: fill 16, drop the 17th, drain, then random traffic.
        for (int i = 1; i <= 16; i++) step(1, 0, 1, 0, 32'hA5A5_0000 + 32'(i), 0);
        step(1, 0, 1, 0, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 250; i++) begin
            step(1, 0, ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 $urandom, ($urandom_range(0, 99) < 6));
        end

        repeat (3) @(posedge clk);
        #1;
        check("a.pending_reads", 64'(exp0.size()), 64'd0);
        check("b.pending_reads", 64'(exp1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
